uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the payload width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all logic updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 p_data  input  DATA_WIDTH  SHALL carry the parallel byte to transmit.
REQ-005 data_valid  input  1  SHALL request transmission of p_data.
REQ-006 par_en  input  1  SHALL enable the parity bit when 1.
REQ-007 par_typ  input  1  SHALL select parity: 0 even, 1 odd.
REQ-008 prescalar  input  6  SHALL give clk cycles per bit; legal values 8, 16, 32.
REQ-009 TX_out  output  1  SHALL be the registered serial line, idle high.
REQ-010 busy  output  1  SHALL be high while a frame is in progress.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-012 The block SHALL accept a frame only on a rising edge where state=IDLE and data_valid=1.
REQ-013 The block SHALL ignore data_valid at every other edge, with no queueing.
REQ-014 On the accepting edge, the block SHALL latch p_data, par_en, par_typ and the effective prescalar, enter START, and drive TX_out=0 and busy=1 on that same edge.
REQ-015 Input changes after acceptance SHALL NOT affect the frame in progress.
REQ-016 The effective prescalar SHALL be the latched value if it is 8, 16 or 32, and 8 for any other value.
REQ-017 Each bit SHALL be held on TX_out for exactly prescalar clk cycles, timed by an edge counter running 0..prescalar-1 that clears at every bit boundary.
REQ-018 Bit order SHALL be: start (0), DATA_WIDTH data bits LSB first, parity bit if par_en=1, then one stop bit (1).
REQ-019 A bit counter SHALL run 0..DATA_WIDTH-1 in DATA; after the last data bit the FSM SHALL go to PARITY if par_en=1, otherwise to STOP.
REQ-020 The parity bit SHALL be the XOR of the latched data when par_typ=0, and its inverse when par_typ=1.
REQ-021 At the end of the stop bit the FSM SHALL enter IDLE, with busy=0 and TX_out=1 on that edge.
REQ-022 busy SHALL stay high for exactly (DATA_WIDTH+2+par_en)*prescalar cycles.
REQ-023 Consecutive frames SHALL be separated by at least one idle cycle, because acceptance is possible only in IDLE.
REQ-024 In IDLE, TX_out SHALL be 1 and the counters SHALL be held at 0.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL set state=IDLE, TX_out=1, busy=0 and clear all counters and latched registers.
REQ-026 Reset SHALL take precedence over data_valid on the same edge.
REQ-027 Reset mid-frame SHALL abort the frame, and TX_out SHALL read 1 from the next edge.
REQ-028 After rst deasserts, the first data_valid in IDLE SHALL start a complete, correct frame.

Verification
REQ-029 p_data=0xA5, par_en=1, par_typ=0, prescalar=8 -> TX_out = 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; busy high for 88 cycles.
REQ-030 p_data=0x01, par_en=1, par_typ=1, prescalar=16 -> parity bit 0; busy high for 176 cycles.
REQ-031 p_data=0xFF, par_en=0, prescalar=32 -> 0, then eight 1s, then stop 1; busy high for 320 cycles, with no parity slot.
REQ-032 data_valid=1 with p_data=0x00 while busy=1 -> the frame in progress is unchanged; a data_valid pulse one cycle after busy falls starts a new frame.
REQ-033 rst pulsed during data bit 3 -> next edge TX_out=1 and busy=0; the following frame with 0x5A is bit-exact.
REQ-034 prescalar=5 with p_data=0x3C -> each bit is 8 cycles wide.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: handshake and serial-line bundle for the uart_tx transmitter.
//   p_data     : parallel payload to transmit (DATA_WIDTH bits)
//   data_valid : request to send p_data (honoured only while idle)
//   par_en     : 1 = append a parity bit
//   par_typ    : parity select, 0 = even, 1 = odd
//   prescalar  : clk cycles per bit (8, 16 or 32; anything else means 8)
//   TX_out     : registered serial line, idle high
//   busy       : high while a frame is being shifted out
// master = the block feeding bytes in; slave = the transmitter itself.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescalar;
  logic                  TX_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescalar,
    input  TX_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescalar,
    output TX_out, busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: parameterised UART transmitter.
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, one stop (1).
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : uart_tx_if.slave (p_data, data_valid, par_en, par_typ, prescalar in;
//         TX_out, busy out)
// A frame is accepted only in IDLE; inputs are latched on the accepting edge
// and ignored until the line returns to IDLE.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_d;
  logic [5:0]            edge_cnt, edge_cnt_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q;
  logic [5:0]            presc_q, presc_eff;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept, bit_done, last_data;

  assign accept    = (state == IDLE) && bus.data_valid;
  assign bit_done  = (edge_cnt == presc_q - 6'd1);
  assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));

  always_comb begin
    presc_eff = 6'd8;
    if (bus.prescalar == 6'd8 || bus.prescalar == 6'd16 || bus.prescalar == 6'd32)
      presc_eff = bus.prescalar;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.data_valid) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / counter next values. TX_out is registered, so the line value is
  // chosen from the state being entered; that puts the start bit on the line
  // on the accepting edge and the idle level on the closing edge.
  always_comb begin
    edge_cnt_d = (state == IDLE || bit_done) ? '0 : edge_cnt + 6'd1;

    bit_cnt_d = '0;
    if (state == DATA && !(bit_done && last_data))
      bit_cnt_d = bit_done ? bit_cnt + BW'(1) : bit_cnt;

    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_cnt_d];
      PARITY:  tx_d = (^data_q) ^ par_typ_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Counters, line register and frame latches
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt_d;
      bit_cnt  <= bit_cnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      if (accept) begin
        data_q    <= bus.p_data;
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
        presc_q   <= presc_eff;
      end
    end
  end

  assign bus.TX_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (DATA_WIDTH = 8).
// Frames come from a vector table plus hand-written sequences for busy-time
// requests, back-to-back frames and mid-frame reset. Expected line slots are
// pushed to a scoreboard when a frame is launched and popped when the
// serial output is captured.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8)) u_if ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] presc;
    int         exp_presc;
    int         exp_cycles;
    logic       exp_par;
  } vec_t;

  typedef struct {
    logic bit_val;
    int   width;
  } slot_t;

  slot_t sb[$];
  vec_t  vecs[6];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input vec_t v);
    logic [7:0] d;
    d = v.data;
    sb.push_back('{1'b0, v.exp_presc});
    for (int i = 0; i < 8; i++) sb.push_back('{d[i], v.exp_presc});
    if (v.pe) sb.push_back('{v.exp_par, v.exp_presc});
    sb.push_back('{1'b1, v.exp_presc});
  endtask

  // Launch a frame. If wait_neg is 0 the caller is already at a negedge.
  // After the accepting edge all inputs are scrambled so a design that
  // failed to latch them would corrupt the frame.
  task automatic send(input vec_t v, input bit wait_neg);
    if (wait_neg) @(negedge clk);
    u_if.p_data     = v.data;
    u_if.par_en     = v.pe;
    u_if.par_typ    = v.pt;
    u_if.prescalar  = v.presc;
    u_if.data_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.data_valid = 1'b0;
    u_if.p_data     = ~v.data;
    u_if.par_en     = ~v.pe;
    u_if.par_typ    = ~v.pt;
    u_if.prescalar  = (v.exp_presc == 32) ? 6'd16 : 6'd32;
    push_frame(v);
  endtask

  // Capture the line while busy (bounded), then compare against the scoreboard.
  // Returns at the first negedge where busy is low.
  task automatic check_frame(input string name, input int exp_cycles);
    logic samples[$];
    int   n;
    int   pos;
    n = 0;
    @(negedge clk);
    while (u_if.busy === 1'b1 && n < 1000) begin
      samples.push_back(u_if.TX_out);
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, n, exp_cycles);
    chk({name, "_idle_line"}, int'(u_if.TX_out), 1);
    pos = 0;
    for (int s = 0; sb.size() > 0; s++) begin
      slot_t sl;
      int    got;
      sl  = sb.pop_front();
      got = int'(sl.bit_val);
      for (int c = 0; c < sl.width; c++) begin
        if (pos >= samples.size()) begin
          if (got == int'(sl.bit_val)) got = 2;
        end else if (samples[pos] !== sl.bit_val && got == int'(sl.bit_val)) begin
          got = (samples[pos] === 1'b1) ? 1 : (samples[pos] === 1'b0) ? 0 : 3;
        end
        pos++;
      end
      chk($sformatf("%s_slot%0d", name, s), got, int'(sl.bit_val));
    end
  endtask

  initial begin
    vec_t v;
    int   busy_seen;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd8,  8,  88,  1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 6'd16, 16, 176, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 6'd32, 32, 320, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 6'd5,  8,  80,  1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 6'd0,  8,  88,  1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 6'd16, 16, 176, 1'b1};

    u_if.p_data     = '0;
    u_if.data_valid = 1'b0;
    u_if.par_en     = 1'b0;
    u_if.par_typ    = 1'b0;
    u_if.prescalar  = 6'd8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", int'(u_if.TX_out), 1);
    chk("reset_busy", int'(u_if.busy), 0);
    rst = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i], 1'b1);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_cycles);
    end

    // Requests with p_data=0 while busy must not disturb or queue
    send(vecs[0], 1'b1);
    fork
      check_frame("hold", 88);
      begin
        repeat (10) @(negedge clk);
        u_if.p_data     = 8'h00;
        u_if.data_valid = 1'b1;
        repeat (60) @(negedge clk);
        u_if.data_valid = 1'b0;
      end
    join
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (u_if.busy !== 1'b0) busy_seen = 1;
    end
    chk("no_queue", busy_seen, 0);

    // Request one cycle after busy falls starts a new frame immediately
    send(vecs[1], 1'b1);
    check_frame("b2b_first", 176);
    send(vecs[0], 1'b0);
    check_frame("b2b_second", 88);

    // Reset wins over data_valid on the same edge
    @(negedge clk);
    rst             = 1'b1;
    u_if.data_valid = 1'b1;
    u_if.p_data     = 8'h81;
    u_if.prescalar  = 6'd8;
    @(posedge clk);
    #1;
    rst             = 1'b0;
    u_if.data_valid = 1'b0;
    @(negedge clk);
    chk("rst_prec_busy", int'(u_if.busy), 0);
    chk("rst_prec_tx", int'(u_if.TX_out), 1);

    // Reset during data bit 3 (slot 4 => cycles 32..39 at prescalar 8)
    send(vecs[0], 1'b1);
    sb.delete();
    repeat (36) @(negedge clk);
    chk("pre_abort_tx", int'(u_if.TX_out), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", int'(u_if.TX_out), 1);
    chk("abort_busy", int'(u_if.busy), 0);
    rst = 1'b0;

    v = '{8'h5A, 1'b1, 1'b1, 6'd16, 16, 176, 1'b1};
    send(v, 1'b1);
    check_frame("after_rst", 176);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
